// File: rtl/uart_rx_frame_parser_if.sv
// Byte stream from the UART receiver, receive gating, and the held-frame status/read port toward the consumer.
interface uart_rx_frame_parser_if;
   logic [7:0] rx_data;
   logic       rx_done_sig;
   logic       rx_en_sig;
   logic       frame_valid;
   logic [7:0] frame_len;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       frame_ack;
   logic       err_len;
   logic       err_chk;
   logic       err_timeout;

   modport master (
      output rx_data, rx_done_sig, rd_addr, frame_ack,
      input  rx_en_sig, frame_valid, frame_len, rd_data, err_len, err_chk, err_timeout
   );

   modport slave (
      input  rx_data, rx_done_sig, rd_addr, frame_ack,
      output rx_en_sig, frame_valid, frame_len, rd_data, err_len, err_chk, err_timeout
   );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Length-prefixed, XOR-checked frame parser; all outputs registered, frame_valid one cycle after the CHK byte.
// A good frame is held with rx_en_sig low until frame_ack; malformed or stalled frames give one-cycle error pulses.
module uart_rx_frame_parser #(
   parameter int         MAX_LEN = 16,
   parameter logic [7:0] HEADER  = 8'hAA,
   parameter int         TIMEOUT = 50000
) (
   input logic                   i_clk,
   input logic                   i_rst,
   uart_rx_frame_parser_if.slave bus
);
   localparam int             AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int             DEPTH    = 1 << AW;
   localparam int             GW       = $clog2(TIMEOUT + 1);
   localparam logic [GW-1:0]  GAP_LAST = GW'(TIMEOUT - 1);
   localparam logic [7:0]     MAX_LEN8 = 8'(MAX_LEN);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LEN     = 3'd1;
   localparam logic [2:0] ST_PAYLOAD = 3'd2;
   localparam logic [2:0] ST_CHK     = 3'd3;
   localparam logic [2:0] ST_HOLD    = 3'd4;

   logic [2:0]    r_state;
   logic [2:0]    w_state_nxt;
   logic [7:0]    r_len;
   logic [7:0]    r_idx;
   logic [7:0]    r_xor;
   logic [GW-1:0] r_gap;
   logic [7:0]    r_buf [DEPTH];

   logic          r_frame_valid;
   logic [7:0]    r_frame_len;
   logic [7:0]    r_rd_data;
   logic          r_rx_en;
   logic          r_err_len;
   logic          r_err_chk;
   logic          r_err_timeout;

   logic          w_in_frame;
   logic          w_gap_exp;
   logic          w_len_ok;
   logic          w_chk_ok;
   logic          w_last_pay;
   logic          w_pay_wr;

   always_comb begin
      w_in_frame = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
      // A byte landing on the expiry cycle wins over the timeout.
      w_gap_exp  = w_in_frame && !bus.rx_done_sig && (r_gap == GAP_LAST);
      w_len_ok   = (bus.rx_data != 8'h00) && (bus.rx_data <= MAX_LEN8);
      w_chk_ok   = (bus.rx_data == r_xor);
      w_last_pay = (r_idx == (r_len - 8'd1));
      w_pay_wr   = (r_state == ST_PAYLOAD) && bus.rx_done_sig;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.rx_done_sig && (bus.rx_data == HEADER))
               w_state_nxt = ST_LEN;
         end
         ST_LEN: begin
            if (bus.rx_done_sig)
               w_state_nxt = w_len_ok ? ST_PAYLOAD : ST_IDLE;
            else if (w_gap_exp)
               w_state_nxt = ST_IDLE;
         end
         ST_PAYLOAD: begin
            if (bus.rx_done_sig) begin
               if (w_last_pay)
                  w_state_nxt = ST_CHK;
            end else if (w_gap_exp) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CHK: begin
            if (bus.rx_done_sig)
               w_state_nxt = w_chk_ok ? ST_HOLD : ST_IDLE;
            else if (w_gap_exp)
               w_state_nxt = ST_IDLE;
         end
         ST_HOLD: begin
            if (bus.frame_ack)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_len         <= 8'h00;
         r_idx         <= 8'h00;
         r_xor         <= 8'h00;
         r_gap         <= '0;
         r_frame_valid <= 1'b0;
         r_frame_len   <= 8'h00;
         r_rd_data     <= 8'h00;
         r_rx_en       <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_chk     <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_rx_en       <= (w_state_nxt != ST_HOLD);
         r_err_len     <= (r_state == ST_LEN) && bus.rx_done_sig && !w_len_ok;
         r_err_chk     <= (r_state == ST_CHK) && bus.rx_done_sig && !w_chk_ok;
         r_err_timeout <= w_gap_exp;

         if (w_in_frame && !bus.rx_done_sig)
            r_gap <= r_gap + GW'(1);
         else
            r_gap <= '0;

         if ((r_state == ST_LEN) && bus.rx_done_sig && w_len_ok) begin
            r_len <= bus.rx_data;
            r_xor <= bus.rx_data;
            r_idx <= 8'h00;
         end

         if (w_pay_wr) begin
            r_xor <= r_xor ^ bus.rx_data;
            r_idx <= r_idx + 8'd1;
         end

         if ((r_state == ST_CHK) && bus.rx_done_sig && w_chk_ok) begin
            r_frame_len   <= r_len;
            r_frame_valid <= 1'b1;
         end

         if ((r_state == ST_HOLD) && bus.frame_ack)
            r_frame_valid <= 1'b0;

         if (bus.rd_addr < MAX_LEN8)
            r_rd_data <= r_buf[bus.rd_addr[AW-1:0]];
         else
            r_rd_data <= 8'h00;
      end
   end

   // Payload storage is deliberately left out of reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_pay_wr)
         r_buf[r_idx[AW-1:0]] <= bus.rx_data;
   end

   assign bus.rx_en_sig   = r_rx_en;
   assign bus.frame_valid = r_frame_valid;
   assign bus.frame_len   = r_frame_len;
   assign bus.rd_data     = r_rd_data;
   assign bus.err_len     = r_err_len;
   assign bus.err_chk     = r_err_chk;
   assign bus.err_timeout = r_err_timeout;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed vector table plus hand-written sequences for reset, max length, timeout and mid-frame reset.
module tb_uart_rx_frame_parser;
   localparam int TO = 40;

   typedef struct {
      logic [7:0] dat;
      logic       done;
      logic       ack;
      logic [7:0] addr;
      logic       chk_rd;
      logic [7:0] rd;
      logic       vld;
      logic [7:0] len;
      logic       en;
      logic       el;
      logic       ec;
   } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;
   vec_t vq[$];
   logic [7:0] tb_b;
   logic [7:0] tb_x;

   uart_rx_frame_parser_if bus ();

   uart_rx_frame_parser #(
      .MAX_LEN (16),
      .HEADER  (8'hAA),
      .TIMEOUT (TO)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] e);
      n_cmp++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, e);
      end
   endtask

   task automatic send(input logic [7:0] d);
      bus.rx_data     = d;
      bus.rx_done_sig = 1'b1;
      tick();
      bus.rx_done_sig = 1'b0;
   endtask

   task automatic add(input logic [7:0] d, input logic dn, input logic ack, input logic [7:0] a,
                      input logic cr, input logic [7:0] rd, input logic vld, input logic [7:0] len,
                      input logic en, input logic el, input logic ec);
      vec_t v;
      v.dat = d; v.done = dn; v.ack = ack; v.addr = a; v.chk_rd = cr; v.rd = rd;
      v.vld = vld; v.len = len; v.en = en; v.el = el; v.ec = ec;
      vq.push_back(v);
   endtask

   task automatic vb(input logic [7:0] d, input logic vld, input logic [7:0] len,
                     input logic en, input logic el, input logic ec);
      add(d, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, vld, len, en, el, ec);
   endtask

   task automatic vr(input logic [7:0] a, input logic [7:0] rd, input logic vld,
                     input logic [7:0] len, input logic en);
      add(8'h00, 1'b0, 1'b0, a, 1'b1, rd, vld, len, en, 1'b0, 1'b0);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.rx_data = 8'h00; bus.rx_done_sig = 1'b0; bus.frame_ack = 1'b0; bus.rd_addr = 8'h00;

      // good frame, reads, byte during HOLD, ack
      vb(8'hAA,0,0,1,0,0); vb(8'h03,0,0,1,0,0); vb(8'h11,0,0,1,0,0); vb(8'h22,0,0,1,0,0);
      vb(8'h33,0,0,1,0,0); vb(8'h03,1,3,0,0,0);
      vr(8'd0,8'h11,1,3,0); vr(8'd1,8'h22,1,3,0); vr(8'd2,8'h33,1,3,0); vr(8'd16,8'h00,1,3,0);
      add(8'h55,1,0,8'd0,1,8'h11,1,3,0,0,0);
      add(8'h00,0,1,8'd0,0,8'h00,0,3,1,0,0);
      // bad checksum then back-to-back good frame
      vb(8'hAA,0,3,1,0,0); vb(8'h02,0,3,1,0,0); vb(8'h55,0,3,1,0,0); vb(8'h66,0,3,1,0,0);
      vb(8'h00,0,3,1,0,1);
      vb(8'hAA,0,3,1,0,0); vb(8'h02,0,3,1,0,0); vb(8'h10,0,3,1,0,0); vb(8'h20,0,3,1,0,0);
      vb(8'h32,1,2,0,0,0);
      vr(8'd0,8'h10,1,2,0); vr(8'd1,8'h20,1,2,0);
      add(8'h99,1,1,8'd0,0,8'h00,0,2,1,0,0);
      vb(8'h02,0,2,1,0,0);
      vr(8'd0,8'h10,0,2,1);
      // length errors then a one-byte frame
      vb(8'hAA,0,2,1,0,0); vb(8'h00,0,2,1,1,0); vb(8'hAA,0,2,1,0,0); vb(8'h11,0,2,1,1,0);
      vb(8'hAA,0,2,1,0,0); vb(8'h01,0,2,1,0,0); vb(8'h7E,0,2,1,0,0); vb(8'h7F,1,1,0,0,0);
      vr(8'd0,8'h7E,1,1,0);
      add(8'h00,0,1,8'd0,0,8'h00,0,1,1,0,0);
      // garbage and embedded header bytes
      vb(8'h00,0,1,1,0,0); vb(8'hFF,0,1,1,0,0); vb(8'hAA,0,1,1,0,0); vb(8'h02,0,1,1,0,0);
      vb(8'hAA,0,1,1,0,0); vb(8'hAA,0,1,1,0,0); vb(8'h02,1,2,0,0,0);
      vr(8'd0,8'hAA,1,2,0); vr(8'd1,8'hAA,1,2,0);
      add(8'h00,0,1,8'd0,0,8'h00,0,2,1,0,0);

      tick(); tick();
      check("rst_en",   {7'd0, bus.rx_en_sig}, 8'h00);
      check("rst_vld",  {7'd0, bus.frame_valid}, 8'h00);
      check("rst_len",  bus.frame_len, 8'h00);
      check("rst_rd",   bus.rd_data, 8'h00);
      check("rst_errs", {5'd0, bus.err_len, bus.err_chk, bus.err_timeout}, 8'h00);
      rst = 1'b0;
      tick();
      check("rst_rel_en", {7'd0, bus.rx_en_sig}, 8'h01);

      for (int i = 0; i < vq.size(); i++) begin
         bus.rx_data     = vq[i].dat;
         bus.rx_done_sig = vq[i].done;
         bus.frame_ack   = vq[i].ack;
         bus.rd_addr     = vq[i].addr;
         tick();
         bus.rx_done_sig = 1'b0;
         bus.frame_ack   = 1'b0;
         check($sformatf("row%0d_vld", i), {7'd0, bus.frame_valid}, {7'd0, vq[i].vld});
         check($sformatf("row%0d_len", i), bus.frame_len, vq[i].len);
         check($sformatf("row%0d_en", i),  {7'd0, bus.rx_en_sig}, {7'd0, vq[i].en});
         check($sformatf("row%0d_errs", i), {5'd0, bus.err_len, bus.err_chk, bus.err_timeout},
               {5'd0, vq[i].el, vq[i].ec, 1'b0});
         if (vq[i].chk_rd)
            check($sformatf("row%0d_rd", i), bus.rd_data, vq[i].rd);
      end

      // maximum-length frame
      bus.rd_addr = 8'd0;
      send(8'hAA); send(8'h10);
      tb_x = 8'h10;
      for (int k = 0; k < 16; k++) begin
         tb_b = 8'(k * 7 + 3);
         tb_x = tb_x ^ tb_b;
         send(tb_b);
      end
      send(tb_x);
      check("max_vld", {7'd0, bus.frame_valid}, 8'h01);
      check("max_len", bus.frame_len, 8'd16);
      bus.rd_addr = 8'd15; tick();
      check("max_rd15", bus.rd_data, 8'h6C);
      bus.rd_addr = 8'd16; tick();
      check("max_rd16", bus.rd_data, 8'h00);
      bus.frame_ack = 1'b1; tick(); bus.frame_ack = 1'b0;
      check("max_ack_vld", {7'd0, bus.frame_valid}, 8'h00);

      // timeout expiry
      send(8'hAA); send(8'h04); send(8'h01);
      for (int k = 1; k < TO; k++) begin
         tick();
         check($sformatf("to_quiet%0d", k), {7'd0, bus.err_timeout}, 8'h00);
      end
      tick();
      check("to_pulse", {7'd0, bus.err_timeout}, 8'h01);
      tick();
      check("to_pulse_end", {7'd0, bus.err_timeout}, 8'h00);
      send(8'h55); send(8'hAA); send(8'h01); send(8'h55); send(8'h54);
      check("to_after_vld", {7'd0, bus.frame_valid}, 8'h01);
      check("to_after_len", bus.frame_len, 8'd1);
      bus.frame_ack = 1'b1; tick(); bus.frame_ack = 1'b0;

      // byte on the expiry cycle
      send(8'hAA); send(8'h04); send(8'h01);
      for (int k = 1; k < TO; k++) tick();
      send(8'h02);
      check("exp_byte_noerr", {7'd0, bus.err_timeout}, 8'h00);
      send(8'h03); send(8'h04); send(8'h00);
      check("exp_byte_vld", {7'd0, bus.frame_valid}, 8'h01);
      check("exp_byte_len", bus.frame_len, 8'd4);
      bus.rd_addr = 8'd3; tick();
      check("exp_byte_rd3", bus.rd_data, 8'h04);
      bus.frame_ack = 1'b1; tick(); bus.frame_ack = 1'b0;

      // reset mid-payload
      send(8'hAA); send(8'h03); send(8'h11);
      rst = 1'b1;
      tick();
      check("mid_rst_en",   {7'd0, bus.rx_en_sig}, 8'h00);
      check("mid_rst_len",  bus.frame_len, 8'h00);
      check("mid_rst_rd",   bus.rd_data, 8'h00);
      check("mid_rst_errs", {5'd0, bus.err_len, bus.err_chk, bus.err_timeout}, 8'h00);
      rst = 1'b0;
      tick();
      check("mid_rel_en",   {7'd0, bus.rx_en_sig}, 8'h01);
      check("mid_rel_vld",  {7'd0, bus.frame_valid}, 8'h00);
      for (int k = 0; k < TO + 2; k++) tick();
      check("mid_rel_errs", {5'd0, bus.err_len, bus.err_chk, bus.err_timeout}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_frame_parser.md
# uart_rx_frame_parser

Byte-level frame parser that sits directly downstream of the UART receive path. It consumes each received byte, qualified by the one-cycle `rx_done_sig` pulse, and gates further reception through `rx_en_sig`. It extracts length-prefixed, XOR-checked frames into an internal payload buffer. It holds each good frame for the consumer until acknowledged, and reports malformed or stalled frames as error pulses.

## Interface
- `MAX_LEN`, 16: maximum payload length in bytes; valid range 1..255.
- `HEADER`, 8'hAA: start-of-frame byte.
- `TIMEOUT`, 50000: maximum number of clk cycles allowed between bytes inside a frame.
- `clk`  in  1  system clock; the block has one clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only in a cycle where `rx_done_sig`=1.
- `rx_done_sig`  in  1  one-cycle pulse: `rx_data` holds a new byte.
- `rx_en_sig`  out  1  receive enable back to the UART receiver; 1 = parser can accept bytes.
- `frame_valid`  out  1  level; a checked frame is held in the buffer.
- `frame_len`  out  8  payload length of the held frame.
- `rd_addr`  in  8  payload buffer read index.
- `rd_data`  out  8  registered payload byte read from `rd_addr`.
- `frame_ack`  in  1  consumer releases the held frame.
- `err_len`  out  1  one-cycle pulse: the LEN byte was 0 or greater than `MAX_LEN`.
- `err_chk`  out  1  one-cycle pulse: checksum mismatch.
- `err_timeout`  out  1  one-cycle pulse: the inter-byte gap exceeded `TIMEOUT`.

## Operation
- Frame format on the wire: `HEADER`, LEN, LEN payload bytes, CHK.
- Checksum rule: CHK = XOR of LEN and every payload byte.
- States: IDLE, LEN, PAYLOAD, CHK, HOLD.
- IDLE:
  - A byte equal to `HEADER` moves the FSM to LEN.
  - Any other byte is silently discarded.
- LEN:
  - LEN=0 or LEN>`MAX_LEN`: pulse `err_len`, return to IDLE.
  - Otherwise latch LEN, seed the running XOR with LEN, clear the byte index, move to PAYLOAD.
- PAYLOAD:
  - Each byte is written to buf[index], XORed into the running checksum, and the index is incremented.
  - After byte number LEN, move to CHK.
  - A byte equal to `HEADER` is ordinary data here; there is no resynchronisation.
- CHK:
  - CHK equals the running XOR: `frame_len`<=LEN, `frame_valid`<=1, move to HOLD.
  - Mismatch: pulse `err_chk`, return to IDLE; `frame_valid` and `frame_len` are unchanged.
- HOLD:
  - `rx_en_sig`=0.
  - Any `rx_done_sig` arriving in this state is ignored; no buffer write, no state change.
  - `frame_ack`=1 clears `frame_valid` and returns the FSM to IDLE.
- `frame_ack` while `frame_valid`=0 is ignored.
- `rx_en_sig` is 1 in IDLE, LEN, PAYLOAD and CHK, and 0 in HOLD and during reset.
- Timeout:
  - The gap counter clears on every accepted byte and counts only in LEN, PAYLOAD and CHK.
  - When it reaches `TIMEOUT` cycles without a byte: pulse `err_timeout`, return to IDLE.
- Read port:
  - `rd_data` <= buf[`rd_addr`] every cycle.
  - `rd_addr` >= `MAX_LEN` returns 8'h00.
  - Indices at or above `frame_len` return stale contents.
- The buffer is not cleared by reset; its contents are don't-care until the first frame is written.
- Counter widths: index is 8 bits; the gap counter is ceil(log2(`TIMEOUT`+1)) bits.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: `rx_en_sig`=0, `frame_valid`=0, `frame_len`=0, `rd_data`=0, all error outputs 0.
  - `rx_en_sig` rises in the first cycle after `rst` deasserts.
- Reset mid-frame: the partial frame is abandoned with no error pulse.
- All inputs are sampled on the rising edge of `clk`; every output is registered.
- Latencies:
  - CHK byte accepted at edge N: `frame_valid`=1 and `rx_en_sig`=0 from cycle N+1.
  - Error pulses are high for exactly the cycle after the offending byte, or after timeout expiry.
  - `frame_ack` sampled at edge N: `frame_valid`=0 and `rx_en_sig`=1 from cycle N+1.
  - `rd_data` is valid one cycle after `rd_addr` is applied.
- Simultaneous events:
  - `rx_done_sig` in the same cycle as timeout expiry: the byte is accepted and the counter clears; no error.
  - `frame_ack` and `rx_done_sig` in the same cycle in HOLD: the ack is taken, the byte is dropped, next state is IDLE.
  - Bytes may arrive back-to-back, one per cycle, at full rate in every non-HOLD state.

## Test plan
- Good frame: AA 03 11 22 33 CHK=03^11^22^33=0x03 -> `frame_valid`=1, `frame_len`=3; reads at addr 0,1,2 return 11,22,33; `rx_en_sig`=0 until `frame_ack`, then 1 one cycle later.
- Bad checksum: AA 02 55 66 00 -> one-cycle `err_chk` pulse, `frame_valid` stays 0, FSM in IDLE; an immediately following good frame is accepted.
- Length errors: AA 00, then AA 11 with `MAX_LEN`=16 -> two `err_len` pulses; a following AA 01 7E 7F -> valid frame with `frame_len`=1.
- Garbage and embedded header: 00 FF AA 02 AA AA 02 -> garbage discarded; frame valid, payload AA AA (checksum 0x02).
- Timeout: AA 04 01, then silence for `TIMEOUT` cycles -> `err_timeout` pulse at exactly `TIMEOUT` cycles after the last byte; a byte landing on the expiry cycle produces no error.
- Reset mid-PAYLOAD and bytes during HOLD -> after reset, outputs return to their reset values with no error pulses; bytes sent during HOLD leave the buffer and `frame_len` unchanged.
